// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, widths and sequencer state type for the ALU issue path
package alu_pkg;
  localparam int W = 16;
  localparam int OPC_W = 3;
  localparam logic [2:0] OPC_NEG = 3'd0;
  localparam logic [2:0] OPC_INC = 3'd1;
  localparam logic [2:0] OPC_ADD2 = 3'd2;
  localparam logic [2:0] OPC_SHADD = 3'd3;
  localparam logic [2:0] OPC_AND = 3'd4;
  localparam logic [2:0] OPC_OR = 3'd5;
  localparam logic [2:0] OPC_PACK = 3'd6;
  localparam logic [2:0] OPC_INC7 = 3'd7;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
endpackage

// File: rtl/alu_issue_seq_stat.sv
// alu_stat_cnt: zero/negative/issue counters, clear has priority over increment
module alu_stat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stat_clr,
  input  logic        inc,
  input  logic        zer,
  input  logic        neg,
  output logic [15:0] zer_cnt,
  output logic [15:0] neg_cnt,
  output logic [15:0] op_cnt
);
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      zer_cnt <= '0;
      neg_cnt <= '0;
      op_cnt <= '0;
    end else if (inc) begin
      zer_cnt <= zer_cnt + {15'b0, zer};
      neg_cnt <= neg_cnt + {15'b0, neg};
      op_cnt <= op_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: registered command issue to the ALU and result hand-off; ALU_STAT_CNT_EN adds result counters
module alu_issue_seq import alu_pkg::*; #(
  parameter int W = 16,
  parameter int OPC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPC_W-1:0] cmd_opc,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_c,
  input  logic             cmd_acc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_c,
  output logic [OPC_W-1:0] alu_opc,
  input  logic [W-1:0]     alu_w,
  input  logic             alu_neg,
  input  logic             alu_zer,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_w,
  output logic             res_neg,
  output logic             res_zer,
  output logic [W-1:0]     acc
`ifdef ALU_STAT_CNT_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      zer_cnt,
  output logic [15:0]      neg_cnt,
  output logic [15:0]      op_cnt
`endif
);
  state_t state, state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (cmd_valid ? ISSUE : IDLE) :
                state == ISSUE ? HOLD : (res_ready ? IDLE : HOLD);
    cmd_ready = state == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_c <= 1'b0;
      alu_opc <= '0;
      res_valid <= 1'b0;
      res_w <= '0;
      res_neg <= 1'b0;
      res_zer <= 1'b0;
      acc <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        alu_a <= cmd_acc ? acc : cmd_a;
        alu_b <= cmd_b;
        alu_c <= cmd_c;
        alu_opc <= cmd_opc;
      end
      if (state == ISSUE) begin
        res_w <= alu_w;
        res_neg <= alu_neg;
        res_zer <= alu_zer;
        acc <= alu_w;
        res_valid <= 1'b1;
      end
      if (state == HOLD && res_ready) res_valid <= 1'b0;
    end
  end
`ifdef ALU_STAT_CNT_EN
  alu_stat_cnt u_stat (
    .clk(clk),
    .rst(rst),
    .stat_clr(stat_clr),
    .inc(state == ISSUE),
    .zer(alu_zer),
    .neg(alu_neg),
    .zer_cnt(zer_cnt),
    .neg_cnt(neg_cnt),
    .op_cnt(op_cnt)
  );
`endif
endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequencer directly upstream of the 16-bit combinational ALU (ops: negate, increment, add, shift-add, AND, OR, byte-pack).
- Accepts commands over a valid/ready handshake and latches operands, optionally substituting the internal accumulator for A.
- Drives the ALU from registers, captures w/neg/zer one cycle later, and presents the registered result downstream over a second valid/ready handshake.

Parameters:
- W, 16, datapath width; must match the ALU width.
- OPC_W, 3, opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_opc  in  OPC_W  ALU opcode.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- cmd_c  in  1  carry/aux bit passed to the ALU.
- cmd_acc  in  1  1 = use the accumulator as A and ignore cmd_a.
- alu_a  out  W  registered A to the ALU.
- alu_b  out  W  registered B to the ALU.
- alu_c  out  1  registered C to the ALU.
- alu_opc  out  OPC_W  registered opcode to the ALU.
- alu_w  in  W  ALU result.
- alu_neg  in  1  ALU negative flag.
- alu_zer  in  1  ALU zero flag.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_w  out  W  captured result.
- res_neg  out  1  captured negative flag.
- res_zer  out  1  captured zero flag.
- acc  out  W  current accumulator value.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE. The following outputs are all 0: cmd_ready (it rises combinationally once state = IDLE after reset), alu_a, alu_b, alu_c, alu_opc, res_valid, res_w, res_neg, res_zer, acc.
- State machine: IDLE, ISSUE, HOLD.
- cmd_ready = (state == IDLE), decoded combinationally from the state register.
- IDLE: when cmd_valid is high, the command is accepted on that edge.
  - alu_a <= cmd_acc ? acc : cmd_a.
  - alu_b <= cmd_b; alu_c <= cmd_c; alu_opc <= cmd_opc.
  - Next state = ISSUE.
  - With cmd_valid low, stay in IDLE and hold the ALU input registers.
- ISSUE: the ALU settles during this cycle. On the edge:
  - res_w <= alu_w; res_neg <= alu_neg; res_zer <= alu_zer.
  - acc <= alu_w.
  - res_valid <= 1; next state = HOLD.
- HOLD: res_w, res_neg and res_zer stay stable while res_valid is high.
  - When res_ready is high: res_valid <= 0 and next state = IDLE.
  - No new command is accepted in the HOLD cycle itself.
  - res_ready may already be high on entry to HOLD; in that case the state is in HOLD for exactly one cycle.
- Latency and throughput:
  - Command acceptance to res_valid high: 2 edges.
  - Minimum spacing between accepted commands: 3 cycles.
- ALU input registers hold their last values outside IDLE acceptance, so the ALU inputs do not toggle while a result is pending.
- Accumulator: updated only on the ISSUE edge.
  - A command with cmd_acc = 1 issued right after a result uses that result, because acc was updated before re-entry to IDLE.
- Widths: all values are W bits and unsigned at the interface. No extension or truncation is performed here.
- Reset mid-operation: rst in ISSUE or HOLD returns to IDLE on that edge, clears res_valid and acc, and drops the pending result.
- rst overrides every other input on the same edge.
- Simultaneous events:
  - cmd_valid is ignored whenever cmd_ready is low; the upstream must hold the command.
  - res_ready is ignored outside HOLD.

Optional Feature:
- Macro ALU_STAT_CNT_EN.
- When defined, add these outputs:
  - zer_cnt (16 bits): count of captured results with alu_zer = 1.
  - neg_cnt (16 bits): count of captured results with alu_neg = 1.
  - op_cnt (16 bits): count of issued commands.
- Counter rules:
  - Counters increment on the ISSUE edge, wrap at 0xFFFF -> 0, and reset to 0 on rst.
  - Input stat_clr (1 bit) zeroes all counters synchronously.
  - If stat_clr coincides with an increment, the clear wins.
- When not defined: no counter ports and no counter logic; the core behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants: OPC_NEG=0, OPC_INC=1, OPC_ADD2=2, OPC_SHADD=3, OPC_AND=4, OPC_OR=5, OPC_PACK=6, OPC_INC7=7.
  - the state enum typedef (IDLE/ISSUE/HOLD).
  - the width constants W and OPC_W.
- Optional sub-module alu_stat_cnt holds the three counters and is instantiated only under ALU_STAT_CNT_EN. The FSM and registers stay in alu_issue_seq.

Test Plan:
- Bench: the real ALU is wired to the alu_* ports.
- Reset check: assert rst for 2 cycles, then release -> all outputs 0, cmd_ready = 1.
- AND op: opc=4, A=0x00F0, B=0x0FF0, cmd_acc=0, res_ready=1 -> res_valid high 2 edges after acceptance with res_w=0x00F0, res_zer=0, res_neg=0; cmd_ready returns high 1 cycle later.
- Accumulator chain: opc=5 with A=0x8000, B=0x0001, then opc=4 with cmd_acc=1, cmd_a=0xFFFF (ignored), B=0x8000 -> first res_w=0x8001 with res_neg=1; second res_w=0x8000.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_w stable, cmd_ready=0 throughout, and a cmd_valid pulse is not accepted; raising res_ready gives res_valid=0 next cycle.
- Reset mid-operation: assert rst in ISSUE -> next cycle state IDLE, res_valid=0, acc=0; the next command behaves normally.
- With ALU_STAT_CNT_EN: issue 3 ops giving results 0, 0x8000, 0x0001 -> zer_cnt=1, neg_cnt=1, op_cnt=3; a stat_clr pulse -> all counters 0.
